ks_pipe_adder: RTL and testbench
================================

Name: ks_pipe_adder

Overview:
Parametrised, pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface. It generalises the fixed 8-bit combinational KS adder in three ways: arbitrary power-of-two width, selectable pipeline registers between prefix levels, and a subtract mode. It also adds a multi-beat chain mode, in which a beat's carry-in is the carry-out of the previous beat. It sits in the arithmetic datapath as the wide-add primitive for multi-word operands and accumulators.

Parameters:
WIDTH, 32, operand width; power of two, at least 4.
LEVELS, $clog2(WIDTH), number of prefix levels; derived, do not override.
STAGE_MASK, {LEVELS{1'b0}}, bit k=1 places a pipeline register after prefix level k+1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in; used only when in_chain=0 and in_sub=0
in_sub  in  1  1 = A - B (B inverted)
in_chain  in  1  1 = carry-in comes from the previous beat's carry-out
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  WIDTH  sum or difference
out_cout  out  1  carry-out; for subtract, 1 = no borrow
out_ovf  out  1  signed overflow: carry into MSB XOR carry-out
out_p  out  WIDTH  bitwise propagate (A ^ B') of this beat
out_g  out  WIDTH  bitwise generate (A & B') of this beat

Behaviour:
- Reset is asynchronous and active-low.
  - Values while reset is asserted: out_valid=0; out_sum, out_cout, out_ovf, out_p, out_g = 0; all stage valid bits = 0; chain carry register = 0.
- Stage 0 (combinational):
  - B' = in_sub ? ~in_b : in_b.
  - p = in_a ^ B', g = in_a & B'.
  - cin is not folded into g[0]; carry-in is applied late (see output stage).
- Prefix network:
  - LEVELS Kogge-Stone levels of standard (g,p) black cells, span 2^(k-1) at level k.
  - Group (G,P) is carried for every bit position to the end.
  - A register follows level k only where STAGE_MASK[k-1]=1. Each such register holds p, g, prefix G/P, sub, chain, cin and a valid bit.
- Output stage:
  - Effective carry-in c = in_chain ? chain_carry : (in_sub ? 1 : in_cin), using the stage-carried flags.
  - carry[i] = G[i-1:0] | (P[i-1:0] & c), with carry[0] = c.
  - sum[i] = p[i] ^ carry[i].
  - cout = G[W-1:0] | (P[W-1:0] & c).
  - ovf = carry[W-1] ^ cout.
  - Results load the always-present output register.
- Latency: popcount(STAGE_MASK) + 1 cycles from acceptance to out_valid, with no stalls.
- Flow control:
  - Global stall: en = !out_valid || out_ready.
  - in_ready = en. All pipeline registers and the output register advance only when en=1.
  - Bubbles are not collapsed. Order is strictly preserved.
- Chain carry register:
  - Loads cout whenever a valid beat enters the output register.
  - Because of in-order delivery, it always holds the carry-out of the beat immediately preceding the one in the output stage.
  - A chained beat that follows a bubble still uses the last real carry.
  - Not altered by bubbles or stalls.
- Subtract with chain: the chained carry is used unmodified as the carry-in (carry = not-borrow convention). The first word of a multi-word subtract must have in_chain=0.
- First beat after reset with in_chain=1 uses carry 0.
- Reset mid-operation: all in-flight beats are discarded. No partial result appears after reset deasserts.
- in_a, in_b and flags are sampled only on handshake. Values are don't-care when in_valid=0.

Decomposition:
- Package ks_pkg:
  - (g,p) struct typedef.
  - Black-cell function: G = g1 | p1&g0, P = p1&p0.
  - clog2 helper.
  - Power-of-two width check constant.
- Sub-module ks_prefix_level:
  - Parameters WIDTH and SPAN.
  - Combinational, operates on full G/P vectors; positions below SPAN pass through.
  - The top level instantiates LEVELS of these with generate-selected registers between them.

Test Plan:
- WIDTH=32, STAGE_MASK=0: A=0xFFFFFFFF, B=0x1, cin=0 -> one cycle later out_sum=0x00000000, out_cout=1, out_ovf=0.
- 64-bit chained add: beat0 A=0xFFFFFFFF, B=1, chain=0; beat1 A=0, B=0, chain=1.
  - Expected: beat0 sum=0x00000000, cout=1; beat1 sum=0x00000001, cout=0.
  - Repeat with STAGE_MASK=5'b11111, back-to-back beats; same results.
- Subtract and overflow:
  - A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - A=0x7FFFFFFF, B=1, add -> sum=0x80000000, cout=0, ovf=1.
  - A=0x80000000, B=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
- Backpressure, STAGE_MASK=5'b10101 (latency 4): stream 8 beats, hold out_ready=0 for 3 cycles mid-stream.
  - Expected: in_ready=0 in exactly those cycles; 8 results in order, none lost or duplicated; out_sum stable while stalled.
- Reset mid-stream: 3 beats in flight, pull rst_n low asynchronously.
  - Expected: out_valid drops immediately; after release, a chained beat A=1, B=1 gives sum=2 (chain carry=0).
- WIDTH=8 exhaustive A, B for both cin values and both sub values, across all STAGE_MASK values -> matches a behavioural + model bit-exactly, including cout, ovf, out_p and out_g.

Source files
------------

// File: rtl/ks_pkg.sv
// ks_pkg: shared types and helpers for the Kogge-Stone pipelined adder.
package ks_pkg;

  // One (generate, propagate) pair for a single bit or bit group.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Flags that travel alongside the operand vectors through the pipe.
  typedef struct packed {
    logic valid;
    logic sub;
    logic chain;
    logic cin;
  } flags_t;

  // Standard black cell: combine a higher group with the adjacent lower group.
  function automatic gp_t ks_black(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int ks_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Width must be a power of two and at least 4 bits.
  function automatic bit ks_is_pow2(input int n);
    return (n >= 4) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// ks_prefix_level: one Kogge-Stone prefix level over full-width G/P vectors.
// Bits below SPAN already hold their final group value and pass through.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < SPAN) begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end else begin : g_cell
      gp_t r;
      assign r      = ks_black(gp_t'({g_i[i], p_i[i]}), gp_t'({g_i[i-SPAN], p_i[i-SPAN]}));
      assign g_o[i] = r.g;
      assign p_o[i] = r.p;
    end
  end

endmodule

// File: rtl/ks_pipe_adder.sv
// ks_pipe_adder: parametrised pipelined Kogge-Stone adder/subtractor with a
// valid/ready stream interface and multi-beat carry chaining. Carry-in is
// applied late, in the output stage, so chained beats never wait on the prefix.
module ks_pipe_adder
  import ks_pkg::*;
#(
  parameter int                WIDTH      = 32,
  parameter int                LEVELS     = ks_clog2(WIDTH),
  parameter logic [LEVELS-1:0] STAGE_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g
);

  if (!ks_is_pow2(WIDTH)) begin : g_width_chk
    $error("ks_pipe_adder: WIDTH must be a power of two and at least 4");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;

  // Index k holds the values after prefix level k (and its optional register).
  logic [WIDTH-1:0] p_a  [LEVELS+1];
  logic [WIDTH-1:0] g_a  [LEVELS+1];
  logic [WIDTH-1:0] gg_a [LEVELS+1];
  logic [WIDTH-1:0] pp_a [LEVELS+1];
  flags_t           f_a  [LEVELS+1];

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, p_q, g_q;
  logic             cout_q, ovf_q, chain_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign b_eff   = in_sub ? ~in_b : in_b;
  assign p_a[0]  = in_a ^ b_eff;
  assign g_a[0]  = in_a & b_eff;
  assign pp_a[0] = in_a ^ b_eff;
  assign gg_a[0] = in_a & b_eff;
  assign f_a[0]  = '{valid: in_valid, sub: in_sub, chain: in_chain, cin: in_cin};

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    logic [WIDTH-1:0] gg_w, pp_w;

    ks_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << (k - 1))
    ) u_lvl (
      .g_i (gg_a[k-1]),
      .p_i (pp_a[k-1]),
      .g_o (gg_w),
      .p_o (pp_w)
    );

    if (STAGE_MASK[k-1]) begin : g_reg
      logic [WIDTH-1:0] p_sq, g_sq, gg_sq, pp_sq;
      flags_t           f_sq;

      // Pipeline register after this level; advances only on the global enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_sq  <= '0;
          g_sq  <= '0;
          gg_sq <= '0;
          pp_sq <= '0;
          f_sq  <= '0;
        end else if (en) begin
          p_sq  <= p_a[k-1];
          g_sq  <= g_a[k-1];
          gg_sq <= gg_w;
          pp_sq <= pp_w;
          f_sq  <= f_a[k-1];
        end
      end

      assign p_a[k]  = p_sq;
      assign g_a[k]  = g_sq;
      assign gg_a[k] = gg_sq;
      assign pp_a[k] = pp_sq;
      assign f_a[k]  = f_sq;
    end else begin : g_wire
      assign p_a[k]  = p_a[k-1];
      assign g_a[k]  = g_a[k-1];
      assign gg_a[k] = gg_w;
      assign pp_a[k] = pp_w;
      assign f_a[k]  = f_a[k-1];
    end
  end

  flags_t           f_last;
  logic [WIDTH-1:0] gg_last, pp_last;
  logic             c_eff;
  logic [WIDTH-1:0] carry_d, sum_d;
  logic             cout_d, ovf_d;

  assign f_last  = f_a[LEVELS];
  assign gg_last = gg_a[LEVELS];
  assign pp_last = pp_a[LEVELS];

  // Late carry-in: chained beats take the carry-out of the previous real beat.
  always_comb begin
    c_eff   = f_last.chain ? chain_q : (f_last.sub ? 1'b1 : f_last.cin);
    carry_d = {gg_last[WIDTH-2:0] | (pp_last[WIDTH-2:0] & {(WIDTH-1){c_eff}}), c_eff};
    sum_d   = p_a[LEVELS] ^ carry_d;
    cout_d  = gg_last[WIDTH-1] | (pp_last[WIDTH-1] & c_eff);
    ovf_d   = carry_d[WIDTH-1] ^ cout_d;
  end

  // Output register and chain carry; bubbles leave both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      chain_q     <= 1'b0;
    end else if (en) begin
      out_valid_q <= f_last.valid;
      if (f_last.valid) begin
        sum_q   <= sum_d;
        cout_q  <= cout_d;
        ovf_q   <= ovf_d;
        p_q     <= p_a[LEVELS];
        g_q     <= g_a[LEVELS];
        chain_q <= cout_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_p     = p_q;
  assign out_g     = g_q;

endmodule

// File: tb/tb_ks_pipe_adder.sv
// tb_ks_pipe_adder: runs several adder configurations side by side, each with
// its own driver, scoreboard and arithmetic reference model.
module tb_ks_pipe_adder;

  localparam int NCFG = 11;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          cin;
    bit          sub;
    bit          chain;
    bit          dir;
    logic [31:0] esum;
    bit          ecout;
    bit          eovf;
    int          gap;
  } beat_t;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] p;
    logic [31:0] g;
    bit          cout;
    bit          ovf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input int ci, input string s);
    return $sformatf("cfg%0d_%s", ci, s);
  endfunction

  // Integer-arithmetic reference: w-bit add of A, B' and the effective carry.
  function automatic res_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input bit cin, input bit sub, input bit chain, input bit cprev);
    logic [63:0] m, aa, bb, t, px, gx;
    bit          c;
    res_t        r;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'h0, a} & m;
    bb = (sub ? {32'h0, ~b} : {32'h0, b}) & m;
    c  = chain ? cprev : (sub ? 1'b1 : cin);
    t  = aa + bb + {63'h0, c};
    px = aa ^ bb;
    gx = aa & bb;
    r.sum  = t[31:0] & m[31:0];
    r.cout = t[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
    r.p    = px[31:0];
    r.g    = gx[31:0];
    return r;
  endfunction

  function automatic beat_t mk(input logic [31:0] a, input logic [31:0] b, input bit cin,
                               input bit sub, input bit chain, input bit dir,
                               input logic [31:0] esum, input bit ecout, input bit eovf,
                               input int gap);
    beat_t x;
    x.a = a; x.b = b; x.cin = cin; x.sub = sub; x.chain = chain; x.dir = dir;
    x.esum = esum; x.ecout = ecout; x.eovf = eovf; x.gap = gap;
    return x;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_007F;
      5:       return 32'h0000_0080;
      default: return $urandom();
    endcase
  endfunction

  for (genvar ci = 0; ci < NCFG; ci++) begin : g_cfg
    localparam int W   = (ci < 3) ? 32 : 8;
    localparam int CL  = (ci < 3) ? 5 : 3;
    localparam int MV  = (ci == 0) ? 0 : (ci == 1) ? 31 : (ci == 2) ? 21 : (ci - 3);
    localparam logic [CL-1:0] MASK = MV[CL-1:0];
    localparam int LAT = $countones(MASK) + 1;

    logic         rst_n;
    logic         in_valid, in_ready, in_cin, in_sub, in_chain;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf;
    logic [W-1:0] out_sum, out_p, out_g;

    beat_t cur;
    res_t  sbq[$];
    bit    model_carry;
    bit    bp;

    ks_pipe_adder #(
      .WIDTH      (W),
      .STAGE_MASK (MASK)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .in_chain  (in_chain),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_p     (out_p),
      .out_g     (out_g)
    );

    initial begin : ready_gen
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end

    // Monitor: a LAT-deep delay line predicts out_valid/in_ready; the queue
    // holds expected results in acceptance order.
    initial begin : mon
      logic [LAT:0] pm;
      bit           stall;
      logic [W-1:0] held;
      res_t         e;
      pm = '0;
      stall = 1'b0;
      held = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          pm = '0;
          stall = 1'b0;
        end else begin
          chk(tg(ci, "out_valid"), out_valid, pm[LAT-1]);
          chk(tg(ci, "in_ready"), in_ready, !pm[LAT-1] || out_ready);
          if (stall) chk(tg(ci, "stall_hold"), out_sum, held);
          if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
              chk(tg(ci, "unexpected_out"), out_valid, 1'b0);
            end else begin
              e = sbq.pop_front();
              chk(tg(ci, "sum"), out_sum, e.sum[W-1:0]);
              chk(tg(ci, "cout"), out_cout, e.cout);
              chk(tg(ci, "ovf"), out_ovf, e.ovf);
              chk(tg(ci, "p"), out_p, e.p[W-1:0]);
              chk(tg(ci, "g"), out_g, e.g[W-1:0]);
            end
          end
          if (in_valid && in_ready) begin
            e = ref_add(W, cur.a, cur.b, cur.cin, cur.sub, cur.chain, model_carry);
            if (cur.dir) begin
              e.sum  = cur.esum;
              e.cout = cur.ecout;
              e.ovf  = cur.eovf;
            end
            model_carry = e.cout;
            sbq.push_back(e);
          end
          stall = out_valid && !out_ready;
          held  = out_sum;
          if (!pm[LAT-1] || out_ready) pm = {pm[LAT-1:0], in_valid};
        end
      end
    end

    initial begin : drv
      beat_t q[$];
      beat_t b;
      bit    acc;
      int    nr;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_cin = 1'b0;
      in_sub = 1'b0;
      in_chain = 1'b0;
      bp = 1'b0;
      model_carry = 1'b0;
      cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #3;
      chk(tg(ci, "rst_valid"), out_valid, 1'b0);
      chk(tg(ci, "rst_sum"), out_sum, '0);
      chk(tg(ci, "rst_cout"), out_cout, 1'b0);
      chk(tg(ci, "rst_ovf"), out_ovf, 1'b0);
      chk(tg(ci, "rst_p"), out_p, '0);
      chk(tg(ci, "rst_g"), out_g, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int ph = 0; ph < 3; ph++) begin
        q.delete();
        if (ph == 0) begin
          if (W == 32) begin
            q.push_back(mk(32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1, 32'h0000_0000, 1, 0, 0));
            q.push_back(mk(32'h0000_0001, 32'h1, 1, 0, 0, 1, 32'h0000_0003, 0, 0, 0));
            q.push_back(mk(32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1, 32'h0000_0000, 1, 0, 0));
            q.push_back(mk(32'h0000_0000, 32'h0, 0, 0, 1, 1, 32'h0000_0001, 0, 0, 0));
            q.push_back(mk(32'h0000_0005, 32'h7, 0, 1, 0, 1, 32'hFFFF_FFFE, 0, 0, 0));
            q.push_back(mk(32'h7FFF_FFFF, 32'h1, 0, 0, 0, 1, 32'h8000_0000, 0, 1, 0));
            q.push_back(mk(32'h8000_0000, 32'h1, 0, 1, 0, 1, 32'h7FFF_FFFF, 1, 1, 0));
          end
          nr = (W == 32) ? 600 : 6000;
          for (int j = 0; j < nr; j++) begin
            q.push_back(mk(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 0, 0, 0, 0,
                           ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0));
          end
        end else if (ph == 1) begin
          for (int j = 0; j < 3; j++) q.push_back(mk(pick(), pick(), 0, 0, 0, 0, 0, 0, 0, 0));
        end else begin
          q.push_back(mk(32'h1, 32'h1, 0, 0, 1, 1, 32'h0000_0002, 0, 0, 0));
        end

        foreach (q[j]) begin
          b = q[j];
          bp = (ph == 0) && !b.dir;
          in_valid = 1'b0;
          repeat (b.gap) begin
            @(posedge clk);
            #1;
          end
          cur      = b;
          in_a     = b.a[W-1:0];
          in_b     = b.b[W-1:0];
          in_cin   = b.cin;
          in_sub   = b.sub;
          in_chain = b.chain;
          in_valid = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
          end
          if (!acc) chk(tg(ci, "accept_timeout"), acc, 1'b1);
        end
        in_valid = 1'b0;
        bp = 1'b0;

        if (ph == 1) begin
          #2;
          rst_n = 1'b0;
          #1;
          chk(tg(ci, "midrst_valid"), out_valid, 1'b0);
          chk(tg(ci, "midrst_sum"), out_sum, '0);
          chk(tg(ci, "midrst_cout"), out_cout, 1'b0);
          sbq.delete();
          model_carry = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          rst_n = 1'b1;
          @(posedge clk);
          #1;
        end else begin
          for (int t = 0; t < 1000 && sbq.size() != 0; t++) @(posedge clk);
          chk(tg(ci, "drain"), sbq.size(), 0);
          repeat (LAT + 2) @(posedge clk);
          #1;
        end
      end
      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 80000 && done_cnt < NCFG; t++) @(posedge clk);
    chk("all_done", done_cnt, NCFG);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
